argmax_window: RTL



---
 rtl/argmax_window_pkg.sv | 40 ++++
 rtl/argmax_eps_scale.sv | 38 +++
 rtl/argmax_window.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/argmax_window_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : argmax_window_pkg                                      |
// | Desc     : Shared types, Q-format constants and FSM states for    |
// |            the windowed argmax.                                   |
// | Revision : 1.0  initial parametrised release                      |
// +------------------------------------------------------------------+
package argmax_window_pkg;

  localparam int c_lambda_w = 14;
  localparam int c_ang_w    = 11;
  localparam int c_theta_w  = 8;
  localparam int c_eps_w    = 21;

  typedef logic signed [c_lambda_w-1:0] lambda_t;
  typedef logic signed [c_ang_w-1:0]    ang_t;
  typedef logic        [c_theta_w-1:0]  theta_t;
  typedef logic signed [c_eps_w-1:0]    eps_t;

  localparam int c_eps_frac = 20;
  localparam int c_ang_frac = 8;
  localparam int c_pi_frac  = 8;

  // 1/(2*pi) as unsigned Q0.8
  localparam logic [7:0] c_inv_2pi = 8'd40;

  // Left shift needed to move a product of two Q formats onto a target fraction
  function automatic int q_align_shift(input int dst_frac, input int a_frac, input int b_frac);
    return dst_frac - a_frac - b_frac;
  endfunction

  localparam int c_eps_shift = q_align_shift(c_eps_frac, c_ang_frac, c_pi_frac);

  typedef enum logic [0:0] {
    ST_SKIP = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_eps_scale.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : argmax_eps_scale                                       |
// | Desc     : Combinational angle -> eps scaling (ang * 1/(2*pi)),   |
// |            aligned to Q.20 and truncated, no saturation.          |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module argmax_eps_scale
  import argmax_window_pkg::*;
#(
  parameter int         ANG_W   = 11,
  parameter int         EPS_W   = 21,
  parameter logic [7:0] INV_2PI = c_inv_2pi
) (
  input  logic [ANG_W-1:0] ang,
  output logic [EPS_W-1:0] eps
);

  localparam int c_prod_w = ANG_W + 9;
  localparam int c_shl_w  = c_prod_w + c_eps_shift;
  localparam int c_wide_w = (c_shl_w > EPS_W) ? c_shl_w : EPS_W;

  logic signed [c_prod_w-1:0] w_ang_ext;
  logic signed [c_prod_w-1:0] w_coef;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_wide_w-1:0] w_wide;
  logic signed [c_wide_w-1:0] w_shl;

  // Operands pre-extended to product width so the low bits are exact
  assign w_ang_ext = {{9{ang[ANG_W-1]}}, ang};
  assign w_coef    = {{(c_prod_w-8){1'b0}}, INV_2PI};
  assign w_prod    = w_ang_ext * w_coef;
  assign w_wide    = {{(c_wide_w-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
  assign w_shl     = w_wide <<< c_eps_shift;
  assign eps       = EPS_W'(w_shl);

endmodule
`default_nettype wire

// File: rtl/argmax_window.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : argmax_window                                          |
// | Desc     : Streaming block argmax over N valid lambda samples,    |
// |            reports peak, its position and scaled angle (eps).     |
// | Revision : 1.0  initial parametrised release                      |
// +------------------------------------------------------------------+
module argmax_window
  import argmax_window_pkg::*;
#(
  parameter int         N        = 256,
  parameter int         IDX_W    = $clog2(N),
  parameter int         LAMBDA_W = 14,
  parameter int         ANG_W    = 11,
  parameter int         EPS_W    = 21,
  parameter logic [7:0] INV_2PI  = c_inv_2pi,
  parameter bit         TIE_LAST = 1'b1,
  parameter int         SKIP     = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [LAMBDA_W-1:0] lambda_in,
  input  logic [ANG_W-1:0]    angle_in,
  output logic                out_valid,
  output logic [IDX_W-1:0]    theta_out,
  output logic [EPS_W-1:0]    eps_out,
  output logic [LAMBDA_W-1:0] peak_out,
  output logic                drop_out
);

  localparam int                c_skip_w     = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [IDX_W-1:0]  c_last       = IDX_W'(N - 1);
  localparam logic [c_skip_w-1:0] c_skip_init = c_skip_w'(SKIP);
  localparam state_t            c_state_init = (SKIP == 0) ? ST_ACC : ST_SKIP;

  state_t                     r_state, w_state_nxt;
  logic [c_skip_w-1:0]        r_skip_cnt, w_skip_cnt_nxt;
  logic [IDX_W-1:0]           r_pos, w_pos_nxt;
  logic [IDX_W-1:0]           r_idx, w_idx_nxt;
  logic signed [LAMBDA_W-1:0] r_peak, w_peak_nxt;
  logic [ANG_W-1:0]           r_ang, w_ang_nxt;
  logic [IDX_W-1:0]           r_res_idx, w_res_idx_nxt;
  logic signed [LAMBDA_W-1:0] r_res_peak, w_res_peak_nxt;
  logic [ANG_W-1:0]           r_res_ang, w_res_ang_nxt;
  logic                       r_fire, w_fire_nxt;
  logic                       r_drop, w_drop_nxt;
  logic                       w_take;
  logic                       w_is_last;
  logic [EPS_W-1:0]           w_eps;

  logic                       r_out_valid;
  logic [IDX_W-1:0]           r_theta_out;
  logic [EPS_W-1:0]           r_eps_out;
  logic [LAMBDA_W-1:0]        r_peak_out;
  logic                       r_drop_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_state_init;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_skip_cnt_nxt = r_skip_cnt;
    w_pos_nxt      = r_pos;
    w_idx_nxt      = r_idx;
    w_peak_nxt     = r_peak;
    w_ang_nxt      = r_ang;
    w_res_idx_nxt  = r_res_idx;
    w_res_peak_nxt = r_res_peak;
    w_res_ang_nxt  = r_res_ang;
    w_fire_nxt     = 1'b0;
    w_drop_nxt     = 1'b0;
    w_is_last      = (r_pos == c_last);
    w_take         = TIE_LAST ? ($signed(lambda_in) >= r_peak) : ($signed(lambda_in) > r_peak);

    if (in_valid) begin
      if (in_sof) begin
        // A sof on the last slot closes the current block on what it already holds
        if (r_state == ST_ACC) begin
          if (w_is_last) begin
            w_fire_nxt     = 1'b1;
            w_res_idx_nxt  = r_idx;
            w_res_peak_nxt = r_peak;
            w_res_ang_nxt  = r_ang;
          end else if (r_pos != '0) begin
            w_drop_nxt = 1'b1;
          end
        end
        w_state_nxt = ST_ACC;
        w_peak_nxt  = $signed(lambda_in);
        w_ang_nxt   = angle_in;
        w_idx_nxt   = '0;
        w_pos_nxt   = IDX_W'(1);
      end else if (r_state == ST_SKIP) begin
        w_skip_cnt_nxt = r_skip_cnt - 1'b1;
        if (r_skip_cnt == c_skip_w'(1)) begin
          w_state_nxt = ST_ACC;
        end
      end else begin
        if ((r_pos == '0) || w_take) begin
          w_peak_nxt = $signed(lambda_in);
          w_ang_nxt  = angle_in;
          w_idx_nxt  = r_pos;
        end
        if (w_is_last) begin
          w_fire_nxt     = 1'b1;
          w_res_idx_nxt  = w_idx_nxt;
          w_res_peak_nxt = w_peak_nxt;
          w_res_ang_nxt  = w_ang_nxt;
          w_pos_nxt      = '0;
        end else begin
          w_pos_nxt = r_pos + 1'b1;
        end
      end
    end
  end

  argmax_eps_scale #(
    .ANG_W   (ANG_W),
    .EPS_W   (EPS_W),
    .INV_2PI (INV_2PI)
  ) u_eps_scale (
    .ang (r_res_ang),
    .eps (w_eps)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip_cnt  <= c_skip_init;
      r_pos       <= '0;
      r_idx       <= '0;
      r_peak      <= '0;
      r_ang       <= '0;
      r_res_idx   <= '0;
      r_res_peak  <= '0;
      r_res_ang   <= '0;
      r_fire      <= 1'b0;
      r_drop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_theta_out <= '0;
      r_eps_out   <= '0;
      r_peak_out  <= '0;
      r_drop_out  <= 1'b0;
    end else begin
      r_skip_cnt  <= w_skip_cnt_nxt;
      r_pos       <= w_pos_nxt;
      r_idx       <= w_idx_nxt;
      r_peak      <= w_peak_nxt;
      r_ang       <= w_ang_nxt;
      r_res_idx   <= w_res_idx_nxt;
      r_res_peak  <= w_res_peak_nxt;
      r_res_ang   <= w_res_ang_nxt;
      r_fire      <= w_fire_nxt;
      r_drop      <= w_drop_nxt;
      r_out_valid <= r_fire;
      r_drop_out  <= r_drop;
      // Result snapshot is taken one cycle earlier so the next block may already overwrite r_peak
      if (r_fire) begin
        r_theta_out <= r_res_idx;
        r_peak_out  <= r_res_peak;
        r_eps_out   <= w_eps;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign theta_out = r_theta_out;
  assign eps_out   = r_eps_out;
  assign peak_out  = r_peak_out;
  assign drop_out  = r_drop_out;

endmodule
`default_nettype wire
